// File: rtl/fp_mul_sched_pkg.sv
// Shared types and constants for the shared FP multiplier scheduler.
package fp_mul_sched_pkg;
  localparam int IDW     = 3;  // wide enough for up to 8 requesters
  localparam int LAT_DEF = 3;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } mul_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer moves past the winner.
module rr_arbiter
  import fp_mul_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    ptr_d    = ptr_q;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = IDW'(idx);
        ptr_d      = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fp_mul_sched.sv
// Shares one fixed-latency FP multiplier between NREQ requesters with per-requester credits
// and a tag pipe that routes each result back to its owner.
module fp_mul_sched
  import fp_mul_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 24,
  parameter int LAT     = LAT_DEF,
  parameter int MAX_OUT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*WIDTH-1:0]   req_a_i,
  input  logic [NREQ*WIDTH-1:0]   req_b_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic                    mul_issue_o,
  output logic [WIDTH-1:0]        mul_a_o,
  output logic [WIDTH-1:0]        mul_b_o,
  input  logic [WIDTH-1:0]        mul_result_i,
  output logic [NREQ-1:0]         resp_valid_o,
  output logic [$clog2(NREQ)-1:0] resp_id_o,
  output logic [WIDTH-1:0]        resp_data_o,
  output logic                    busy_o
);
  localparam int RIDW = $clog2(NREQ);
  localparam int CW   = $clog2(MAX_OUT + 1);

  logic [NREQ-1:0]          eligible, gnt, dec;
  logic [IDW-1:0]           gnt_id;
  logic                     hs;
  logic                     issue_q, issue_d;
  logic [WIDTH-1:0]         a_q, a_d, b_q, b_d;
  mul_tag_t                 tag_q [LAT+1];
  mul_tag_t                 tag_d [LAT+1];
  mul_tag_t                 tout;
  logic [NREQ-1:0]          resp_valid_q, resp_valid_d;
  logic [RIDW-1:0]          resp_id_q, resp_id_d;
  logic [WIDTH-1:0]         resp_data_q, resp_data_d;
  logic [NREQ-1:0][CW-1:0]  cnt_q, cnt_d;
  logic                     busy_q, busy_d;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++)
      eligible[i] = req_valid_i[i] && (cnt_q[i] != CW'(MAX_OUT));
  end

  // Reset also masks grants so ready reads zero while reset is held.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (eligible),
    .en_i     (enable_i && !rst),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign hs   = |gnt;
  assign tout = tag_q[LAT];

  always_comb begin
    issue_d = hs;
    a_d     = a_q;
    b_d     = b_q;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        a_d = req_a_i[i*WIDTH +: WIDTH];
        b_d = req_b_i[i*WIDTH +: WIDTH];
      end
    tag_d[0] = '{valid: hs, id: gnt_id};
    for (int k = 1; k <= LAT; k++) tag_d[k] = tag_q[k-1];
  end

  // Stage LAT lines up with mul_result_i; its id selects the owner and returns a credit.
  always_comb begin
    dec          = '0;
    resp_valid_d = '0;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    if (tout.valid) begin
      resp_id_d   = tout.id[RIDW-1:0];
      resp_data_d = mul_result_i;
      for (int i = 0; i < NREQ; i++)
        if (tout.id == IDW'(i)) dec[i] = 1'b1;
      resp_valid_d = dec;
    end
  end

  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i] && !dec[i])      cnt_d[i] = cnt_q[i] + CW'(1);
      else if (dec[i] && !gnt[i]) cnt_d[i] = cnt_q[i] - CW'(1);
      if (cnt_d[i] != '0) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
      resp_valid_q <= '0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      issue_q      <= issue_d;
      a_q          <= a_d;
      b_q          <= b_d;
      for (int k = 0; k <= LAT; k++) tag_q[k] <= tag_d[k];
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready_o  = gnt;
  assign mul_issue_o  = issue_q;
  assign mul_a_o      = a_q;
  assign mul_b_o      = b_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign resp_data_o  = resp_data_q;
  assign busy_o       = busy_q;
endmodule

// File: doc/fp_mul_sched.md
Name: fp_mul_sched

Overview:
Shares one fixed-latency 24-bit floating-point multiplier pipeline (1 sign, 8 exponent, 15 mantissa bits) between NREQ requesters. It arbitrates requests round-robin, with one issue per cycle, and registers operands into the multiplier. A tag pipeline tracks the requester ID alongside each operation, and the block routes each result back to its owner. Per-requester credit counters bound the number of in-flight operations.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 24, operand/result width
LAT, 3, cycles from mul_issue_o/operands valid to mul_result_i valid (multiplier pipeline depth)
MAX_OUT, 4, max in-flight operations per requester (1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
enable_i  in  1  permits new grants; in-flight operations drain regardless
req_valid_i  in  NREQ  request valid per requester
req_a_i  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b_i  in  NREQ*WIDTH  operand B, same packing
req_ready_o  out  NREQ  one-hot (or zero) grant; transfer when valid&ready
mul_issue_o  out  1  operands on mul_a_o/mul_b_o valid this cycle
mul_a_o  out  WIDTH  registered operand A to multiplier
mul_b_o  out  WIDTH  registered operand B to multiplier
mul_result_i  in  WIDTH  multiplier result, valid LAT cycles after mul_issue_o
resp_valid_o  out  NREQ  one-hot result strobe, registered
resp_id_o  out  $clog2(NREQ)  owner of resp_data_o
resp_data_o  out  WIDTH  registered result, broadcast to all requesters
busy_o  out  1  any requester has outstanding count != 0

Behaviour:
- Reset (async assert, sync release): req_ready_o, mul_issue_o, mul_a_o, mul_b_o, resp_valid_o, resp_id_o, resp_data_o and busy_o are 0. The round-robin pointer, all credit counters and all tag stages are 0.
- Eligibility: eligible[i] = req_valid_i[i] & (count[i] != MAX_OUT).
- Grant: when enable_i=1, the first eligible index at or after rr_ptr (wrapping) gets req_ready_o=1. Otherwise req_ready_o=0. req_ready_o is combinational from req_valid_i; requesters must not make valid depend on ready.
- rr_ptr becomes (g+1) mod NREQ after a grant to g. It is unchanged when there is no grant.
- Issue: on the handshake edge, mul_a_o/mul_b_o load the winner's operands and mul_issue_o=1 for the next cycle. With no handshake, mul_issue_o=0 and the operands hold.
- Tag pipe: LAT+1 stages of {valid, id}. Stage 0 loads on the handshake edge; stage k is valid in cycle 1+k relative to the handshake cycle 0. Stage LAT aligns with mul_result_i.
- Response: on the edge where stage LAT is valid, resp_data_o<=mul_result_i, resp_id_o<=id, and resp_valid_o<=onehot(id). Otherwise resp_valid_o<=0 and data/id hold.
- Handshake-to-resp_valid_o latency is LAT+2 (5 at default).
- Credits:
  - count[i] increments on a handshake by i.
  - It decrements on the edge that loads a response for i.
  - Both events on the same edge leave it unchanged.
  - Counters never overflow, by eligibility.
- busy_o is registered as OR of count[i]!=0 after the update.
- Results are never back-pressured; requesters must accept resp_valid_o.
- Reset mid-operation drops all in-flight operations. Multiplier results arriving afterwards are ignored because the tags were cleared. The multiplier itself has no reset.

Decomposition:
- Package fp_mul_sched_pkg:
  - ID width constant.
  - Typedef mul_tag_t {logic valid; logic [IDW-1:0] id}.
  - Default LAT constant shared with the multiplier stage wrappers.
- Sub-module rr_arbiter (NREQ-wide request vector plus enable in; one-hot grant out; internal pointer with async reset).
- The credit counters, operand registers and tag pipe stay in the top module.

Test Plan:
- Single request: req0 a=0x3F8000 (1.0), b=0x400000 (2.0), handshake cycle 0 -> mul_issue_o cycle 1 with those operands; resp_valid_o=4'b0001, resp_id_o=0 in cycle 5, resp_data_o equal to the model multiplier output.
- All four req_valid_i held high, enable_i=1 -> req_ready_o sequence 0001,0010,0100,1000,0001 on consecutive cycles; responses return in the same order, 5 cycles after each grant.
- Credit limit: only req1 valid continuously -> ready high cycles 0-3, low cycle 4, high cycle 5; steady state 4 grants per 5 cycles; count never exceeds 4.
- enable_i dropped at cycle 2 with 2 operations in flight -> no further grants; both responses delivered; busy_o falls the cycle after the last resp_valid_o edge.
- rst asserted in cycle 2 after handshakes in cycles 0-1 -> all outputs 0 immediately; no resp_valid_o afterwards; after release, a fresh request completes in 5 cycles with counters starting at 0.
- Same-edge handshake and response for req2 with count=2 -> count stays 2; busy_o stays 1.
